// File: rtl/hpdcache_mem_wr_merge_pkg.sv
// Memory write-interface types and widths shared by the write-merge stage and its bench.
package hpdcache_mem_wr_merge_pkg;

   localparam int unsigned MemAddrWidth = 56;
   localparam int unsigned MemLenWidth  = 8;
   localparam int unsigned MemIdWidth   = 4;
   localparam int unsigned MemDataWidth = 512;

   typedef struct packed {
      logic [MemAddrWidth-1:0] mem_req_addr;
      logic [MemLenWidth-1:0]  mem_req_len;
      logic [2:0]              mem_req_size;
      logic [MemIdWidth-1:0]   mem_req_id;
      logic [1:0]              mem_req_command;
      logic [3:0]              mem_req_atomic;
      logic                    mem_req_cacheable;
   } mem_req_t;

   typedef struct packed {
      logic [MemDataWidth-1:0]   mem_req_w_data;
      logic [MemDataWidth/8-1:0] mem_req_w_be;
      logic                      mem_req_w_last;
   } mem_req_w_t;

endpackage

// File: rtl/hpdcache_mem_wr_merge_fifo.sv
// Register-based FIFO for pending write headers; ready/valid derive only from registered count.
module hpdcache_mem_wr_merge_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             w_i,
   output logic             wok_o,
   input  logic [Width-1:0] wdata_i,
   input  logic             r_i,
   output logic             rok_o,
   output logic [Width-1:0] rdata_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Depth-1:0][Width-1:0] mem_q, mem_d;
   logic [PtrW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PtrW:0]               cnt_q, cnt_d;
   logic                        push, pop;

   assign wok_o   = (cnt_q != (PtrW+1)'(Depth));
   assign rok_o   = (cnt_q != '0);
   assign rdata_o = mem_q[rptr_q];
   assign push    = w_i & wok_o;
   assign pop     = r_i & rok_o;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d        = wptr_q + PtrW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + (PtrW+1)'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - (PtrW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/hpdcache_mem_wr_merge.sv
// Joins the write-header and write-data channels into self-contained beats; the header
// len field decides where a burst ends, the data last flag is only checked against it.
module hpdcache_mem_wr_merge
   import hpdcache_mem_wr_merge_pkg::*;
#(
   parameter int unsigned HdrFifoDepth       = 4,
   parameter type         hpdcache_mem_req_t   = mem_req_t,
   parameter type         hpdcache_mem_req_w_t = mem_req_w_t,
   parameter int unsigned DataWidth          = hpdcache_mem_wr_merge_pkg::MemDataWidth,
   parameter int unsigned AddrWidth          = hpdcache_mem_wr_merge_pkg::MemAddrWidth,
   parameter int unsigned LenWidth           = hpdcache_mem_wr_merge_pkg::MemLenWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  hpdcache_mem_req_t   req_i,
   input  logic                data_valid_i,
   output logic                data_ready_o,
   input  hpdcache_mem_req_w_t data_i,
   output logic                beat_valid_o,
   input  logic                beat_ready_i,
   output hpdcache_mem_req_t   beat_hdr_o,
   output hpdcache_mem_req_w_t beat_data_o,
   output logic                beat_first_o,
   output logic                len_err_o,
   output logic                idle_o
);

   localparam int unsigned HdrWidth  = $bits(hpdcache_mem_req_t);
   localparam int unsigned BeatBytes = DataWidth / 8;

   logic                fifo_rok, fifo_pop;
   logic [HdrWidth-1:0] fifo_rdata;
   hpdcache_mem_req_t   head;

   logic [LenWidth-1:0] beat_cnt_q, beat_cnt_d;
   logic                beat_valid_q, beat_valid_d;
   logic                beat_first_q, beat_first_d;
   logic                len_err_q, len_err_d;
   hpdcache_mem_req_t   beat_hdr_q, beat_hdr_d;
   hpdcache_mem_req_w_t beat_data_q, beat_data_d;
   logic                data_acc, last_c;

   hpdcache_mem_wr_merge_fifo #(
      .Depth (HdrFifoDepth),
      .Width (HdrWidth)
   ) u_hdr_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .w_i     (req_valid_i),
      .wok_o   (req_ready_o),
      .wdata_i (req_i),
      .r_i     (fifo_pop),
      .rok_o   (fifo_rok),
      .rdata_o (fifo_rdata)
   );

   assign head         = hpdcache_mem_req_t'(fifo_rdata);
   // Data only moves when a header is at the head and the output slot frees this cycle.
   assign data_ready_o = fifo_rok & (~beat_valid_q | beat_ready_i);
   assign data_acc     = data_valid_i & data_ready_o;
   assign last_c       = (beat_cnt_q == head.mem_req_len);
   assign fifo_pop     = data_acc & last_c;

   always_comb begin
      beat_cnt_d   = beat_cnt_q;
      beat_valid_d = beat_valid_q;
      beat_first_d = beat_first_q;
      beat_hdr_d   = beat_hdr_q;
      beat_data_d  = beat_data_q;
      len_err_d    = 1'b0;
      if (data_acc) begin
         beat_valid_d            = 1'b1;
         beat_first_d            = (beat_cnt_q == '0);
         beat_hdr_d              = head;
         beat_hdr_d.mem_req_addr = head.mem_req_addr +
                                   AddrWidth'(beat_cnt_q) * AddrWidth'(BeatBytes);
         beat_data_d             = data_i;
         beat_data_d.mem_req_w_last = last_c;
         len_err_d               = (data_i.mem_req_w_last != last_c);
         beat_cnt_d              = last_c ? '0 : beat_cnt_q + LenWidth'(1);
      end else if (beat_ready_i) begin
         beat_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         beat_cnt_q   <= '0;
         beat_valid_q <= 1'b0;
         beat_first_q <= 1'b0;
         len_err_q    <= 1'b0;
         beat_hdr_q   <= '0;
         beat_data_q  <= '0;
      end else begin
         beat_cnt_q   <= beat_cnt_d;
         beat_valid_q <= beat_valid_d;
         beat_first_q <= beat_first_d;
         len_err_q    <= len_err_d;
         beat_hdr_q   <= beat_hdr_d;
         beat_data_q  <= beat_data_d;
      end
   end

   assign beat_valid_o = beat_valid_q;
   assign beat_first_o = beat_first_q;
   assign beat_hdr_o   = beat_hdr_q;
   assign beat_data_o  = beat_data_q;
   assign len_err_o    = len_err_q;
   assign idle_o       = ~fifo_rok & (beat_cnt_q == '0) & ~beat_valid_q;

endmodule

// File: tb/tb_hpdcache_mem_wr_merge.sv
// Directed bench for hpdcache_mem_wr_merge: burst table plus multi-cycle corner sequences.
module tb_hpdcache_mem_wr_merge;
   import hpdcache_mem_wr_merge_pkg::*;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       req_valid_i, req_ready_o;
   mem_req_t   req_i, beat_hdr_o;
   logic       data_valid_i, data_ready_o;
   mem_req_w_t data_i, beat_data_o;
   logic       beat_valid_o, beat_ready_i, beat_first_o, len_err_o, idle_o;

   always #5 clk = ~clk;

   hpdcache_mem_wr_merge dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_i        (req_i),
      .data_valid_i (data_valid_i),
      .data_ready_o (data_ready_o),
      .data_i       (data_i),
      .beat_valid_o (beat_valid_o),
      .beat_ready_i (beat_ready_i),
      .beat_hdr_o   (beat_hdr_o),
      .beat_data_o  (beat_data_o),
      .beat_first_o (beat_first_o),
      .len_err_o    (len_err_o),
      .idle_o       (idle_o)
   );

   typedef struct {
      logic [55:0] addr;
      int          len;
      logic [7:0]  last_mask;
      logic [55:0] exp_last_addr;
      int          exp_err;
      bit          rnd;
   } vec_t;

   typedef struct {
      mem_req_t   h;
      mem_req_w_t d;
      logic       first;
   } beat_t;

   int         errors = 0;
   int         checks = 0;
   mem_req_t   hq[$];
   mem_req_w_t dq[$];
   beat_t      got[$];
   bit         hdr_en, data_en;
   int         rdy_mode;
   int         err_pulses;
   bit         s_req_ready, s_data_ready, s_beat_valid, s_data_acc;
   bit         prev_stall;
   mem_req_t   prev_h;
   mem_req_w_t prev_d;
   vec_t       tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, sample 1ns later, advance to the next negedge.
   task automatic step();
      req_valid_i  = hdr_en && (hq.size() != 0);
      req_i        = (hq.size() != 0) ? hq[0] : '0;
      data_valid_i = data_en && (dq.size() != 0);
      data_i       = (dq.size() != 0) ? dq[0] : '0;
      case (rdy_mode)
         0:       beat_ready_i = 1'b1;
         1:       beat_ready_i = 1'($urandom_range(0, 1));
         default: beat_ready_i = 1'b0;
      endcase
      #1;
      if (prev_stall) begin
         check("stall_hold", {31'b0, beat_valid_o && (beat_hdr_o == prev_h) &&
                              (beat_data_o == prev_d)}, 1);
      end
      s_req_ready  = req_ready_o;
      s_data_ready = data_ready_o;
      s_beat_valid = beat_valid_o;
      s_data_acc   = data_valid_i && data_ready_o;
      if (req_valid_i && req_ready_o) void'(hq.pop_front());
      if (s_data_acc) void'(dq.pop_front());
      if (beat_valid_o && beat_ready_i) got.push_back('{beat_hdr_o, beat_data_o, beat_first_o});
      if (len_err_o) err_pulses++;
      prev_stall = beat_valid_o && !beat_ready_i;
      prev_h     = beat_hdr_o;
      prev_d     = beat_data_o;
      @(negedge clk);
   endtask

   function automatic mem_req_t mk_hdr(input logic [55:0] addr, input int len, input int id);
      mem_req_t h;
      h                 = '0;
      h.mem_req_addr    = addr;
      h.mem_req_len     = 8'(len);
      h.mem_req_size    = 3'd6;
      h.mem_req_id      = 4'(id);
      h.mem_req_command = 2'd1;
      return h;
   endfunction

   function automatic mem_req_w_t mk_data(input logic [31:0] tag, input logic last);
      mem_req_w_t w;
      w                = '0;
      w.mem_req_w_data = 512'(tag);
      w.mem_req_w_be   = '1;
      w.mem_req_w_last = last;
      return w;
   endfunction

   initial begin
      logic [55:0] exp_addr;
      int          cyc;
      rst_ni = 1'b0;
      req_valid_i = 1'b0; req_i = '0; data_valid_i = 1'b0; data_i = '0; beat_ready_i = 1'b0;
      hdr_en = 1'b1; data_en = 1'b1; rdy_mode = 0; err_pulses = 0; prev_stall = 1'b0;
      prev_h = '0; prev_d = '0;

      tbl[0] = '{56'h1000,             3, 8'h08, 56'h10C0,  0, 1'b0};
      tbl[1] = '{56'h2000,             0, 8'h01, 56'h2000,  0, 1'b0};
      tbl[2] = '{56'h3000,             1, 8'h03, 56'h3040,  1, 1'b0};
      tbl[3] = '{56'hFF_FFFF_FFFF_FFC0, 1, 8'h02, 56'h0,     0, 1'b0};
      tbl[4] = '{56'h40,               2, 8'h00, 56'hC0,    1, 1'b0};
      tbl[5] = '{56'h5000,             7, 8'h80, 56'h51C0,  0, 1'b1};

      @(negedge clk); @(negedge clk);
      #1;
      check("rst_idle", {63'b0, idle_o}, 1);
      check("rst_req_ready", {63'b0, req_ready_o}, 1);
      check("rst_data_ready", {63'b0, data_ready_o}, 0);
      check("rst_beat_valid", {63'b0, beat_valid_o}, 0);
      check("rst_len_err", {63'b0, len_err_o}, 0);
      check("rst_hdr", 64'(beat_hdr_o.mem_req_addr), 0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Burst table: one header plus len+1 data beats each.
      for (int i = 0; i < 6; i++) begin
         got.delete();
         err_pulses = 0;
         hq.push_back(mk_hdr(tbl[i].addr, tbl[i].len, i + 1));
         for (int k = 0; k <= tbl[i].len; k++) begin
            dq.push_back(mk_data(32'hD000_0000 + 32'(i * 256 + k), tbl[i].last_mask[k]));
         end
         rdy_mode = tbl[i].rnd ? 1 : 0;
         cyc = 0;
         while (got.size() < tbl[i].len + 1 && cyc < 300) begin
            step();
            cyc++;
         end
         rdy_mode = 0;
         step(); step();
         check($sformatf("v%0d_beats", i), 64'(got.size()), 64'(tbl[i].len + 1));
         foreach (got[k]) begin
            exp_addr = tbl[i].addr + 56'(k) * 56'd64;
            check($sformatf("v%0d_b%0d_addr", i, k), 64'(got[k].h.mem_req_addr), 64'(exp_addr));
            check($sformatf("v%0d_b%0d_first", i, k), {63'b0, got[k].first}, 64'(k == 0));
            check($sformatf("v%0d_b%0d_last", i, k), {63'b0, got[k].d.mem_req_w_last},
                  64'(k == tbl[i].len));
            check($sformatf("v%0d_b%0d_data", i, k), 64'(got[k].d.mem_req_w_data[31:0]),
                  64'(32'hD000_0000 + 32'(i * 256 + k)));
            check($sformatf("v%0d_b%0d_id", i, k), 64'(got[k].h.mem_req_id), 64'(i + 1));
         end
         if (got.size() != 0) begin
            check($sformatf("v%0d_last_addr", i), 64'(got[got.size()-1].h.mem_req_addr),
                  64'(tbl[i].exp_last_addr));
         end
         check($sformatf("v%0d_len_err", i), 64'(err_pulses), 64'(tbl[i].exp_err));
         check($sformatf("v%0d_idle", i), {63'b0, idle_o}, 1);
      end

      // Header FIFO fills with 4 of 5 headers; first pop reopens it one cycle later.
      got.delete();
      data_en = 1'b0;
      for (int j = 0; j < 5; j++) hq.push_back(mk_hdr(56'h9000 + 56'(j * 256), 0, 9));
      for (int j = 0; j < 8; j++) step();
      check("full_req_ready", {63'b0, s_req_ready}, 0);
      check("full_pending", 64'(hq.size()), 1);
      data_en = 1'b1;
      dq.push_back(mk_data(32'hE000_0000, 1'b1));
      step();
      check("full_pop_acc", {63'b0, s_data_acc}, 1);
      check("full_pop_ready", {63'b0, s_req_ready}, 0);
      step();
      check("full_reopen", {63'b0, s_req_ready}, 1);
      for (int j = 1; j < 5; j++) dq.push_back(mk_data(32'hE000_0000 + 32'(j), 1'b1));
      cyc = 0;
      while (got.size() < 5 && cyc < 100) begin
         step();
         cyc++;
      end
      check("full_beats", 64'(got.size()), 5);
      foreach (got[k]) begin
         check($sformatf("full_b%0d_addr", k), 64'(got[k].h.mem_req_addr),
               64'(56'h9000 + 56'(k * 256)));
         check($sformatf("full_b%0d_fl", k), {62'b0, got[k].first, got[k].d.mem_req_w_last}, 3);
      end

      // Data waits for a header; beat appears one cycle after accept.
      step(); step();
      got.delete();
      hdr_en = 1'b0;
      hq.push_back(mk_hdr(56'hA000, 0, 3));
      dq.push_back(mk_data(32'hF000_0001, 1'b1));
      for (int j = 0; j < 10; j++) begin
         step();
         check($sformatf("nohdr_c%0d", j), {62'b0, s_data_ready, s_beat_valid}, 0);
      end
      hdr_en = 1'b1;
      step();
      check("hdr_arrive_no_acc", {63'b0, s_data_acc}, 0);
      step();
      check("hdr_arrive_acc", {63'b0, s_data_acc}, 1);
      check("hdr_arrive_lat0", {63'b0, s_beat_valid}, 0);
      step();
      check("hdr_arrive_lat1", {63'b0, s_beat_valid}, 1);
      check("hdr_arrive_addr", 64'(got.size() != 0 ? got[0].h.mem_req_addr : 56'h1), 64'hA000);

      // Reset in the middle of a stalled burst.
      step();
      got.delete();
      rdy_mode = 2;
      hq.push_back(mk_hdr(56'h7000, 3, 4));
      for (int k = 0; k < 2; k++) dq.push_back(mk_data(32'h7000_0000 + 32'(k), 1'b0));
      for (int j = 0; j < 4; j++) step();
      check("mid_valid", {63'b0, s_beat_valid}, 1);
      check("mid_busy", {63'b0, idle_o}, 0);
      #2 rst_ni = 1'b0;
      #1;
      check("arst_idle", {63'b0, idle_o}, 1);
      check("arst_valid", {63'b0, beat_valid_o}, 0);
      check("arst_ready", {62'b0, req_ready_o, data_ready_o}, 2);
      hq.delete(); dq.delete(); got.delete();
      prev_stall = 1'b0;
      rdy_mode = 0;
      @(negedge clk);
      rst_ni = 1'b1;
      hq.push_back(mk_hdr(56'h8000, 0, 6));
      dq.push_back(mk_data(32'h8000_0000, 1'b1));
      cyc = 0;
      while (got.size() < 1 && cyc < 50) begin
         step();
         cyc++;
      end
      check("post_rst_beats", 64'(got.size()), 1);
      if (got.size() != 0) begin
         check("post_rst_addr", 64'(got[0].h.mem_req_addr), 64'h8000);
         check("post_rst_first", {63'b0, got[0].first}, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
